// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory arbiter: FSM states, owner IDs and the
// IO address window marker (addr[17:16] == 2'b11 selects IO space).
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ROB  = 2'd3
    } owner_t;

    localparam logic [1:0] IO_ADDR_HI = 2'b11;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter and its environment.
//   rdy/clear          : global enable and mispredict flush
//   if_*               : instruction fetch port (always 4 bytes)
//   ld_*               : LSB load port (1/2/4 bytes, zero-extended)
//   rob_*              : ROB commit port (stores and IO reads)
//   mem_*, io_buffer_full : byte-wide RAM port
// slave  = the arbiter side, master = requesters + RAM side.
interface mem_arbiter_if;

    logic        rdy;
    logic        clear;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [2:0]  ld_size;
    logic        ld_done;
    logic [31:0] ld_data;

    logic        rob_req;
    logic        rob_wr;
    logic [31:0] rob_addr;
    logic [2:0]  rob_size;
    logic [31:0] rob_wdata;
    logic        rob_done;
    logic [31:0] rob_rdata;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    modport slave (
        input  rdy, clear,
        input  if_req, if_addr,
        input  ld_req, ld_addr, ld_size,
        input  rob_req, rob_wr, rob_addr, rob_size, rob_wdata,
        input  mem_din, io_buffer_full,
        output if_done, if_data, ld_done, ld_data, rob_done, rob_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, clear,
        output if_req, if_addr,
        output ld_req, ld_addr, ld_size,
        output rob_req, rob_wr, rob_addr, rob_size, rob_wdata,
        output mem_din, io_buffer_full,
        input  if_done, if_data, ld_done, ld_data, rob_done, rob_rdata,
        input  mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares one byte-wide RAM port between instruction fetch,
// LSB loads and ROB commits (stores / IO reads), fixed priority ROB > LD > IF.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over rdy and clear)
//   bus  : mem_arbiter_if.slave bundle (requester ports + RAM port)
// All outputs are registered. A transaction's done pulse appears size+1
// cycles after the grant edge with its data valid in the same cycle.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    state_t      r_state;
    owner_t      r_owner;
    logic [2:0]  r_cnt;
    logic [31:0] r_base;
    logic [2:0]  r_size;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic        r_turn;
    logic        r_if_done;
    logic [31:0] r_if_data;
    logic        r_ld_done;
    logic [31:0] r_ld_data;
    logic        r_rob_done;
    logic [31:0] r_rob_rdata;
    logic [31:0] r_mem_a;
    logic [7:0]  r_mem_dout;
    logic        r_mem_wr;

    logic [2:0]  w_cnt_inc;
    logic [31:0] w_addr_cur;
    logic [31:0] w_addr_next;
    logic [31:0] w_buf_next;
    logic        w_io_stall;

    // Select byte lane idx of a word (lanes above 3 read as zero).
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            3'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        return b;
    endfunction

    // Replace byte lane idx of a word (lanes above 3 are dropped).
    function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [2:0] idx,
                                             input logic [7:0] b);
        logic [31:0] w;
        w = word;
        case (idx)
            3'd0:    w[7:0]   = b;
            3'd1:    w[15:8]  = b;
            3'd2:    w[23:16] = b;
            3'd3:    w[31:24] = b;
            default: w        = word;
        endcase
        return w;
    endfunction

    assign w_cnt_inc   = r_cnt + 3'd1;
    assign w_addr_cur  = r_base + {29'd0, r_cnt};
    assign w_addr_next = r_base + {29'd0, w_cnt_inc};
    // Byte cnt-1 was addressed last cycle, so mem_din now carries it.
    assign w_buf_next  = (r_cnt != 3'd0) ? put_byte(r_buf, r_cnt - 3'd1, bus.mem_din) : r_buf;
    assign w_io_stall  = (r_base[17:16] == IO_ADDR_HI) && bus.io_buffer_full;

    // Arbitration FSM with registered RAM-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_NONE;
            r_cnt       <= 3'd0;
            r_base      <= 32'd0;
            r_size      <= 3'd0;
            r_wdata     <= 32'd0;
            r_buf       <= 32'd0;
            r_turn      <= 1'b0;
            r_if_done   <= 1'b0;
            r_if_data   <= 32'd0;
            r_ld_done   <= 1'b0;
            r_ld_data   <= 32'd0;
            r_rob_done  <= 1'b0;
            r_rob_rdata <= 32'd0;
            r_mem_a     <= 32'd0;
            r_mem_dout  <= 8'd0;
            r_mem_wr    <= 1'b0;
        end else if (bus.rdy) begin
            // Pulses and the RAM strobe default low; issuing branches override.
            r_if_done  <= 1'b0;
            r_ld_done  <= 1'b0;
            r_rob_done <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_a    <= 32'd0;
            r_mem_dout <= 8'd0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    if (r_turn) begin
                        // Bus turnaround after a ROB transaction.
                        r_turn  <= 1'b0;
                        r_owner <= OWN_NONE;
                    end else if (bus.rob_req) begin
                        r_owner <= OWN_ROB;
                        r_base  <= bus.rob_addr;
                        r_size  <= bus.rob_size;
                        r_wdata <= bus.rob_wdata;
                        if (bus.rob_wr) begin
                            r_state <= ST_WRITE;
                        end else begin
                            r_state <= ST_READ;
                            r_mem_a <= bus.rob_addr;
                        end
                    end else if (bus.clear) begin
                        // A flush cycle never grants speculative requesters.
                        r_owner <= OWN_NONE;
                    end else if (bus.ld_req) begin
                        r_owner <= OWN_LD;
                        r_base  <= bus.ld_addr;
                        r_size  <= bus.ld_size;
                        r_wdata <= 32'd0;
                        r_state <= ST_READ;
                        r_mem_a <= bus.ld_addr;
                    end else if (bus.if_req) begin
                        r_owner <= OWN_IF;
                        r_base  <= bus.if_addr;
                        r_size  <= 3'd4;
                        r_wdata <= 32'd0;
                        r_state <= ST_READ;
                        r_mem_a <= bus.if_addr;
                    end else begin
                        r_owner <= OWN_NONE;
                    end
                end
                ST_READ: begin
                    if (bus.clear && (r_owner != OWN_ROB)) begin
                        r_state <= ST_IDLE;
                        r_owner <= OWN_NONE;
                        r_cnt   <= 3'd0;
                    end else if (r_cnt == r_size) begin
                        r_state <= ST_IDLE;
                        r_owner <= OWN_NONE;
                        r_cnt   <= 3'd0;
                        r_turn  <= (r_owner == OWN_ROB);
                        case (r_owner)
                            OWN_IF: begin
                                r_if_done <= 1'b1;
                                r_if_data <= w_buf_next;
                            end
                            OWN_LD: begin
                                r_ld_done <= 1'b1;
                                r_ld_data <= w_buf_next;
                            end
                            OWN_ROB: begin
                                r_rob_done  <= 1'b1;
                                r_rob_rdata <= w_buf_next;
                            end
                            default: begin
                                r_turn <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_buf <= w_buf_next;
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc < r_size) begin
                            r_mem_a <= w_addr_next;
                        end else begin
                            r_mem_a <= 32'd0;
                        end
                    end
                end
                ST_WRITE: begin
                    if (r_cnt == r_size) begin
                        r_rob_done <= 1'b1;
                        r_state    <= ST_IDLE;
                        r_owner    <= OWN_NONE;
                        r_cnt      <= 3'd0;
                        r_turn     <= 1'b1;
                    end else if (w_io_stall) begin
                        r_cnt <= r_cnt;
                    end else begin
                        r_mem_a    <= w_addr_cur;
                        r_mem_dout <= get_byte(r_wdata, r_cnt);
                        r_mem_wr   <= 1'b1;
                        r_cnt      <= w_cnt_inc;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_owner <= OWN_NONE;
                    r_cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.if_done   = r_if_done;
    assign bus.if_data   = r_if_data;
    assign bus.ld_done   = r_ld_done;
    assign bus.ld_data   = r_ld_data;
    assign bus.rob_done  = r_rob_done;
    assign bus.rob_rdata = r_rob_rdata;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_dout  = r_mem_dout;
    assign bus.mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected responses into
// queues, a negedge monitor pops and compares whenever a done pulse or a RAM
// write appears.
module tb_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } rob_exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] q_if[$];
    logic [31:0] q_ld[$];
    rob_exp_t    q_rob[$];
    wr_exp_t     q_wr[$];

    logic [7:0]  ram [0:262143];

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency; it pauses with rdy like the rest
    // of the system. Reset reloads the fixed test pattern.
    always @(posedge clk) begin
        if (rst) begin
            ram[18'h00100] <= 8'h13;
            ram[18'h00101] <= 8'h05;
            ram[18'h00102] <= 8'h00;
            ram[18'h00103] <= 8'h00;
            ram[18'h3FFFF] <= 8'h11;
            ram[18'h00000] <= 8'h22;
            bus.mem_din    <= 8'h00;
        end else if (bus.rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[17:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[17:0]];
        end
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: pulse with nothing expected", name);
    endtask

    // Monitor: compare every done pulse and every RAM write against the queues.
    always @(negedge clk) begin
        wr_exp_t  w;
        rob_exp_t r;
        if (bus.if_done) begin
            if (q_if.size() == 0) unexpected("if_done");
            else check32("if_data", bus.if_data, q_if.pop_front());
        end
        if (bus.ld_done) begin
            if (q_ld.size() == 0) unexpected("ld_done");
            else check32("ld_data", bus.ld_data, q_ld.pop_front());
        end
        if (bus.rob_done) begin
            if (q_rob.size() == 0) unexpected("rob_done");
            else begin
                r = q_rob.pop_front();
                if (r.is_read) check32("rob_rdata", bus.rob_rdata, r.data);
            end
        end
        if (bus.mem_wr) begin
            if (q_wr.size() == 0) unexpected("mem_wr");
            else begin
                w = q_wr.pop_front();
                check32("wr_addr", bus.mem_a, w.addr);
                check32("wr_data", {24'd0, bus.mem_dout}, {24'd0, w.data});
            end
        end
    end

    // Counts edges from the call until the selected done is seen (0=IF,1=LD,2=ROB).
    task automatic wait_done(input int which, input int limit, output int cyc);
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < limit) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            case (which)
                0:       seen = bus.if_done;
                1:       seen = bus.ld_done;
                default: seen = bus.rob_done;
            endcase
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done port %0d: no done within %0d cycles", which, limit);
        end
    endtask

    task automatic do_ld(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
        int c;
        q_ld.push_back(exp);
        bus.ld_req  = 1'b1;
        bus.ld_addr = addr;
        bus.ld_size = size;
        wait_done(1, 30, c);
        bus.ld_req  = 1'b0;
        check32("ld_latency", c, size + 2);
    endtask

    initial begin
        int c, c_rob, c_ld, c_if;
        rst = 1'b1;
        bus.rdy = 1'b1;            bus.clear = 1'b0;
        bus.if_req = 1'b0;         bus.if_addr = 32'd0;
        bus.ld_req = 1'b0;         bus.ld_addr = 32'd0;   bus.ld_size = 3'd0;
        bus.rob_req = 1'b0;        bus.rob_wr = 1'b0;     bus.rob_addr = 32'd0;
        bus.rob_size = 3'd0;       bus.rob_wdata = 32'd0; bus.io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_if_done",   {31'd0, bus.if_done},  32'd0);
        check32("rst_ld_done",   {31'd0, bus.ld_done},  32'd0);
        check32("rst_rob_done",  {31'd0, bus.rob_done}, 32'd0);
        check32("rst_if_data",   bus.if_data,           32'd0);
        check32("rst_ld_data",   bus.ld_data,           32'd0);
        check32("rst_rob_rdata", bus.rob_rdata,         32'd0);
        check32("rst_mem_a",     bus.mem_a,             32'd0);
        check32("rst_mem_wr",    {31'd0, bus.mem_wr},   32'd0);
        check32("rst_mem_dout",  {24'd0, bus.mem_dout}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // IF fetch: grant edge plus 5 more edges until if_done is visible.
        q_if.push_back(32'h00000513);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h00000100;
        wait_done(0, 30, c);
        bus.if_req  = 1'b0;
        check32("if_latency", c, 32'd6);

        // Load sizes and 32-bit address wrap (0xFFFFFFFF then 0x0).
        do_ld(32'h00000100, 3'd1, 32'h00000013);
        do_ld(32'hFFFFFFFF, 3'd2, 32'h00002211);

        // Priority: ROB store, then (after turnaround) LD, then IF.
        q_wr.push_back('{32'h200, 8'hEF});
        q_wr.push_back('{32'h201, 8'hBE});
        q_wr.push_back('{32'h202, 8'hAD});
        q_wr.push_back('{32'h203, 8'hDE});
        q_rob.push_back('{1'b0, 32'd0});
        q_ld.push_back(32'hDEADBEEF);
        q_if.push_back(32'h00000513);
        bus.rob_req = 1'b1; bus.rob_wr = 1'b1; bus.rob_addr = 32'h200;
        bus.rob_size = 3'd4; bus.rob_wdata = 32'hDEADBEEF;
        bus.ld_req = 1'b1;  bus.ld_addr = 32'h200; bus.ld_size = 3'd4;
        bus.if_req = 1'b1;  bus.if_addr = 32'h100;
        fork
            begin wait_done(2, 60, c_rob); bus.rob_req = 1'b0; end
            begin wait_done(1, 60, c_ld);  bus.ld_req  = 1'b0; end
            begin wait_done(0, 60, c_if);  bus.if_req  = 1'b0; end
        join
        check32("prio_rob_cycle", c_rob, 32'd6);
        check32("prio_ld_cycle",  c_ld,  32'd13);
        check32("prio_if_cycle",  c_if,  32'd19);
        repeat (2) @(negedge clk);

        // Clear during an LD read at cnt=1: abort, no ld_done, IF served next.
        bus.ld_req = 1'b1; bus.ld_addr = 32'h100; bus.ld_size = 3'd4;
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus.clear = 1'b1; bus.ld_req = 1'b0;
        @(posedge clk); @(negedge clk);
        bus.clear = 1'b0;
        check32("clr_ld_mem_a",  bus.mem_a, 32'd0);
        check32("clr_ld_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            check32("clr_ld_no_done", {31'd0, bus.ld_done}, 32'd0);
            @(negedge clk);
        end
        q_if.push_back(32'h00000513);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        wait_done(0, 30, c);
        bus.if_req = 1'b0;
        check32("clr_if_latency", c, 32'd6);

        // Clear during a ROB store: both bytes written, one rob_done.
        q_wr.push_back('{32'h300, 8'h78});
        q_wr.push_back('{32'h301, 8'h56});
        q_rob.push_back('{1'b0, 32'd0});
        bus.rob_req = 1'b1; bus.rob_wr = 1'b1; bus.rob_addr = 32'h300;
        bus.rob_size = 3'd2; bus.rob_wdata = 32'h12345678;
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.clear = 1'b0;
        wait_done(2, 20, c);
        bus.rob_req = 1'b0;
        check32("clr_rob_latency", c, 32'd1);
        @(negedge clk);
        check32("clr_rob_single", {31'd0, bus.rob_done}, 32'd0);

        // ROB IO read with clear mid-transfer still completes.
        q_rob.push_back('{1'b1, 32'h00000513});
        bus.rob_req = 1'b1; bus.rob_wr = 1'b0; bus.rob_addr = 32'h100; bus.rob_size = 3'd4;
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus.clear = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.clear = 1'b0;
        wait_done(2, 20, c);
        bus.rob_req = 1'b0;
        check32("rob_rd_latency", c, 32'd3);
        repeat (2) @(negedge clk);

        // IO store stalls while the IO buffer is full.
        bus.io_buffer_full = 1'b1;
        q_wr.push_back('{32'h30000, 8'hA7});
        q_rob.push_back('{1'b0, 32'd0});
        bus.rob_req = 1'b1; bus.rob_wr = 1'b1; bus.rob_addr = 32'h00030000;
        bus.rob_size = 3'd1; bus.rob_wdata = 32'h000000A7;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check32("io_stall_wr", {31'd0, bus.mem_wr}, 32'd0);
        end
        bus.io_buffer_full = 1'b0;
        wait_done(2, 20, c);
        bus.rob_req = 1'b0;
        check32("io_release_latency", c, 32'd2);
        repeat (2) @(negedge clk);

        // rdy low for 2 cycles during an IF read freezes the transfer.
        q_if.push_back(32'h00000513);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(posedge clk); @(posedge clk); @(negedge clk);
        bus.rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); @(negedge clk);
            check32("rdy_hold_mem_a", bus.mem_a, 32'h101);
            check32("rdy_hold_done", {31'd0, bus.if_done}, 32'd0);
        end
        bus.rdy = 1'b1;
        wait_done(0, 20, c);
        bus.if_req = 1'b0;
        check32("rdy_resume_latency", c, 32'd4);
        repeat (2) @(negedge clk);

        // Reset in the middle of a ROB store: abandoned, no done, no more writes.
        q_wr.push_back('{32'h400, 8'h11});
        bus.rob_req = 1'b1; bus.rob_wr = 1'b1; bus.rob_addr = 32'h400;
        bus.rob_size = 3'd4; bus.rob_wdata = 32'h44332211;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b1; bus.rob_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check32("rst_mid_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check32("rst_mid_mem_a",  bus.mem_a, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check32("rst_mid_no_done", {31'd0, bus.rob_done}, 32'd0);
        end

        check32("q_if_empty",  q_if.size(),  32'd0);
        check32("q_ld_empty",  q_ld.size(),  32'd0);
        check32("q_rob_empty", q_rob.size(), 32'd0);
        check32("q_wr_empty",  q_wr.size(),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
